// File: rtl/conv_result_reader.sv
// Captures one ROWSxCOLS binary result map and shows it a row at a time,
// stepped by a synchronized push button, with the row number on a 7-segment digit.
module conv_result_reader #(
    parameter int ROWS        = 6,
    parameter int COLS        = 6,
    parameter int IDX_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   result_valid,
    input  logic [ROWS*COLS-1:0]   result_flat,
    input  logic                   next_btn,
    input  logic                   abort,
    output logic [COLS-1:0]        row_out,
    output logic [IDX_W-1:0]       row_idx,
    output logic                   row_valid,
    output logic                   done,
    output logic                   dropped,
    output logic [6:0]             seg
);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
    localparam logic [6:0]       SEG_DASH = 7'b1000000;

    state_t                 state_q;
    logic [ROWS*COLS-1:0]   buf_q;
    logic [COLS-1:0]        row_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   valid_q;
    logic                   done_q;
    logic                   dropped_q;
    logic [6:0]             seg_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   next_rise;
    logic [IDX_W-1:0]       idx_inc;

    // Digit for a 0-based row index: the display counts rows from 1.
    function automatic logic [6:0] digitSeg(input logic [IDX_W-1:0] idx);
        case (int'(idx))
            0:       return 7'b0000110;
            1:       return 7'b1011011;
            2:       return 7'b1001111;
            3:       return 7'b1100110;
            4:       return 7'b1101101;
            5:       return 7'b1111101;
            6:       return 7'b0000111;
            7:       return 7'b1111111;
            8:       return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [COLS-1:0] rowOf(input logic [ROWS*COLS-1:0] m,
                                              input logic [IDX_W-1:0]     idx);
        return m[int'(idx)*COLS +: COLS];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= next_btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign next_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign idx_inc   = idx_q + IDX_W'(1);

    // The buffer survives abort so only rst wipes a captured map.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            row_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            seg_q     <= '0;
        end else begin
            dropped_q <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                row_q   <= '0;
                idx_q   <= '0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
                seg_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (result_valid) begin
                            buf_q   <= result_flat;
                            state_q <= S_SHOW;
                            idx_q   <= '0;
                            row_q   <= rowOf(result_flat, '0);
                            valid_q <= 1'b1;
                            done_q  <= 1'b0;
                            seg_q   <= digitSeg('0);
                        end else if (state_q == S_DONE && next_rise) begin
                            state_q <= S_IDLE;
                            idx_q   <= '0;
                            done_q  <= 1'b0;
                            seg_q   <= '0;
                        end
                    end
                    S_SHOW: begin
                        if (result_valid) begin
                            dropped_q <= 1'b1;
                        end
                        if (next_rise) begin
                            if (idx_q == LAST_IDX) begin
                                state_q <= S_DONE;
                                row_q   <= '0;
                                valid_q <= 1'b0;
                                done_q  <= 1'b1;
                                seg_q   <= SEG_DASH;
                            end else begin
                                idx_q <= idx_inc;
                                row_q <= rowOf(buf_q, idx_inc);
                                seg_q <= digitSeg(idx_inc);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign row_out   = row_q;
    assign row_idx   = idx_q;
    assign row_valid = valid_q;
    assign done      = done_q;
    assign dropped   = dropped_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_conv_result_reader.sv
// Directed self-checking bench for conv_result_reader: load, step, drop,
// DONE collision, abort and asynchronous reset scenarios.
module tb_conv_result_reader;

    localparam int ROWS = 6;
    localparam int COLS = 6;
    localparam int IDX_W = 3;
    localparam int SYNC_STAGES = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 resultValid;
    logic [ROWS*COLS-1:0] resultFlat;
    logic                 nextBtn;
    logic                 abortIn;
    logic [COLS-1:0]      rowOut;
    logic [IDX_W-1:0]     rowIdx;
    logic                 rowValid;
    logic                 doneOut;
    logic                 droppedOut;
    logic [6:0]           segOut;

    int testsRun = 0;
    int testsFailed = 0;

    // Observed bundle: {row_valid, done, dropped, row_idx, row_out, seg}
    logic [18:0] obs;
    logic [18:0] expv;

    localparam logic [ROWS*COLS-1:0] MAP_A = {6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01};
    localparam logic [ROWS*COLS-1:0] MAP_B = {6'h3F, 6'h3E, 6'h3C, 6'h38, 6'h30, 6'h21};

    logic [6:0] segTab [0:5];
    logic [5:0] rowA [0:5];
    logic [5:0] rowB [0:5];

    conv_result_reader #(
        .ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (resultValid),
        .result_flat  (resultFlat),
        .next_btn     (nextBtn),
        .abort        (abortIn),
        .row_out      (rowOut),
        .row_idx      (rowIdx),
        .row_valid    (rowValid),
        .done         (doneOut),
        .dropped      (droppedOut),
        .seg          (segOut)
    );

    always #5 clk = ~clk;

    assign obs = {rowValid, doneOut, droppedOut, rowIdx, rowOut, segOut};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Button goes high; returns just after the edge where the FSM acts on it.
    task automatic press();
        nextBtn = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
    endtask

    task automatic release_btn();
        nextBtn = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
    endtask

    task automatic load(input logic [ROWS*COLS-1:0] m);
        resultValid = 1'b1;
        resultFlat  = m;
        tick();
        resultValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        expv = '0;
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: got %b expected %b", obs, expv);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        load(MAP_A);
        expv = {1'b1, 1'b0, 1'b0, 3'd0, 6'h01, 7'b0000110};
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL load_row0: got %b expected %b", obs, expv);
        end
    endtask

    task automatic test_step_all();
        for (int k = 1; k <= ROWS; k++) begin
            nextBtn = 1'b1;
            repeat (SYNC_STAGES) tick();
            expv = {1'b1, 1'b0, 1'b0, 3'(k - 1), rowA[k-1], segTab[k-1]};
            testsRun++;
            if (obs !== expv) begin
                testsFailed++;
                $display("[TB] FAIL step_early_%0d: got %b expected %b", k, obs, expv);
            end
            tick();
            if (k < ROWS) expv = {1'b1, 1'b0, 1'b0, 3'(k), rowA[k], segTab[k]};
            else          expv = {1'b0, 1'b1, 1'b0, 3'd5, 6'h00, 7'b1000000};
            testsRun++;
            if (obs !== expv) begin
                testsFailed++;
                $display("[TB] FAIL step_%0d: got %b expected %b", k, obs, expv);
            end
            repeat (7) tick();
            testsRun++;
            if (obs !== expv) begin
                testsFailed++;
                $display("[TB] FAIL hold_%0d: got %b expected %b", k, obs, expv);
            end
            release_btn();
        end
    endtask

    task automatic test_done_collision();
        nextBtn = 1'b1;
        repeat (SYNC_STAGES) tick();
        resultValid = 1'b1;
        resultFlat  = MAP_B;
        tick();
        resultValid = 1'b0;
        expv = {1'b1, 1'b0, 1'b0, 3'd0, rowB[0], segTab[0]};
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL done_collision: got %b expected %b", obs, expv);
        end
        release_btn();
    endtask

    task automatic test_abort();
        for (int k = 1; k <= 3; k++) begin
            press();
            release_btn();
        end
        expv = {1'b1, 1'b0, 1'b0, 3'd3, rowB[3], segTab[3]};
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL abort_pre_row3: got %b expected %b", obs, expv);
        end
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        expv = '0;
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL abort_idle: got %b expected %b", obs, expv);
        end
        press();
        release_btn();
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL abort_btn_ignored: got %b expected %b", obs, expv);
        end
        abortIn     = 1'b1;
        resultValid = 1'b1;
        resultFlat  = MAP_A;
        tick();
        abortIn     = 1'b0;
        resultValid = 1'b0;
        tick();
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL abort_beats_capture: got %b expected %b", obs, expv);
        end
    endtask

    task automatic test_busy_drop();
        load(MAP_A);
        press(); release_btn();
        press(); release_btn();
        resultValid = 1'b1;
        resultFlat  = MAP_B;
        tick();
        resultValid = 1'b0;
        expv = {1'b1, 1'b0, 1'b1, 3'd2, 6'h04, segTab[2]};
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL drop_pulse: got %b expected %b", obs, expv);
        end
        tick();
        expv = {1'b1, 1'b0, 1'b0, 3'd2, 6'h04, segTab[2]};
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL drop_one_cycle: got %b expected %b", obs, expv);
        end
        for (int k = 3; k < ROWS; k++) begin
            press();
            expv = {1'b1, 1'b0, 1'b0, 3'(k), rowA[k], segTab[k]};
            testsRun++;
            if (obs !== expv) begin
                testsFailed++;
                $display("[TB] FAIL drop_keeps_map_%0d: got %b expected %b", k, obs, expv);
            end
            release_btn();
        end
    endtask

    task automatic test_async_reset();
        load(MAP_A);
        press(); release_btn();
        #3;
        rst = 1'b1;
        #1;
        expv = '0;
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got %b expected %b", obs, expv);
        end
        tick();
        rst = 1'b0;
        tick();
        load(MAP_B);
        expv = {1'b1, 1'b0, 1'b0, 3'd0, rowB[0], segTab[0]};
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL reload_after_reset: got %b expected %b", obs, expv);
        end
        press();
        expv = {1'b1, 1'b0, 1'b0, 3'd1, rowB[1], segTab[1]};
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL step_after_reset: got %b expected %b", obs, expv);
        end
        release_btn();
    endtask

    initial begin
        segTab[0] = 7'b0000110; segTab[1] = 7'b1011011; segTab[2] = 7'b1001111;
        segTab[3] = 7'b1100110; segTab[4] = 7'b1101101; segTab[5] = 7'b1111101;
        rowA[0] = 6'h01; rowA[1] = 6'h02; rowA[2] = 6'h04;
        rowA[3] = 6'h08; rowA[4] = 6'h10; rowA[5] = 6'h20;
        rowB[0] = 6'h21; rowB[1] = 6'h30; rowB[2] = 6'h38;
        rowB[3] = 6'h3C; rowB[4] = 6'h3E; rowB[5] = 6'h3F;
        rst         = 1'b1;
        resultValid = 1'b0;
        resultFlat  = '0;
        nextBtn     = 1'b0;
        abortIn     = 1'b0;

        test_reset();
        test_load();
        test_step_all();
        test_done_collision();
        test_abort();
        test_busy_drop();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/conv_result_reader.md
Name: conv_result_reader

Overview:
- Read-out end of the switch-loader/convolution path: captures one finished ROWSxCOLS binary result map from the convolution layer and presents it one row at a time on the output pins.
- Stepped by a debounced-by-synchronizer push button; current row number shown on a 7-segment digit.
- Mirrors the row-by-row switch loader on the input side: rows leave the way they entered.

Parameters:
ROWS, 6, number of result rows (legal 1..9, limited by the single display digit)
COLS, 6, bits per row
IDX_W, 3, width of row index
SYNC_STAGES, 2, flip-flop stages on next_btn before edge detection

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
result_valid  input  1  one-cycle pulse: result_flat holds a complete map
result_flat  input  ROWS*COLS  packed map; row r = bits [r*COLS +: COLS]
next_btn  input  1  asynchronous level from push button; each rising edge advances one row
abort  input  1  synchronous clear to IDLE, highest priority after rst
row_out  output  COLS  currently displayed row
row_idx  output  IDX_W  index of displayed row (0-based)
row_valid  output  1  high while row_out holds a captured row
done  output  1  high after last row has been stepped past
dropped  output  1  one-cycle pulse: result_valid arrived while busy and was ignored
seg  output  7  7-segment pattern {g,f,e,d,c,b,a}, active-high

Behaviour:
- Single clock; clk and asynchronous active-high rst as stated. rst forces: state IDLE, buffer all-zero, row_out 0, row_idx 0, row_valid 0, done 0, dropped 0, seg 7'b0000000, synchronizer and edge-detect flops 0.
- next_btn passes through SYNC_STAGES flops; next_rise = synced & ~synced_prev. Rising input is acted on SYNC_STAGES+1 clock edges after it is sampled. Holding the button high gives exactly one step.
- States: IDLE, SHOW, DONE. All outputs registered.
- IDLE: result_valid=1 -> buffer <= result_flat; next cycle state SHOW, row_idx 0, row_out = row 0, row_valid 1. next_rise ignored.
- SHOW: next_rise with row_idx < ROWS-1 -> row_idx+1, row_out = that row, same edge. next_rise with row_idx = ROWS-1 -> DONE, row_valid 0, row_out 0, done 1, row_idx held.
- SHOW: result_valid -> dropped pulses 1 cycle; buffer, row, and state are unchanged.
- DONE: result_valid -> capture exactly as in IDLE, done 0 the next cycle. next_rise alone -> IDLE, done 0. If both occur in the same cycle, capture wins.
- abort=1 (any state) -> IDLE next edge, row_valid/done/row_idx/row_out cleared, buffer retained. abort together with result_valid: abort wins, no capture, no dropped.
- ROWS=1: first next_rise in SHOW goes directly to DONE.
- seg: IDLE blank 0000000. SHOW shows digit row_idx+1: 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. DONE shows dash 1000000. seg updates on the same edge as row_idx/state.
- rst asserted mid-readout: immediate return to reset values; no partial state survives.

Test Plan:
- Reset then load: pulse result_valid with rows 0..5 = 6'h01,6'h02,6'h04,6'h08,6'h10,6'h20 -> next cycle row_valid=1, row_idx=0, row_out=6'h01, seg=0000110.
- Step all rows: 6 separate next_btn presses, each held for 10 cycles -> row_out steps 6'h02..6'h20 with seg 1011011..1111101, each change SYNC_STAGES+1 cycles after press. 6th press -> done=1, row_valid=0, seg=1000000. Holding the button produces no extra steps.
- Busy drop: result_valid with a different map while in SHOW at row 2 -> dropped high for exactly 1 cycle, row_out still 6'h04. The remaining rows match the first map.
- DONE collision: in DONE, assert next_rise and result_valid in the same cycle -> SHOW with new map row 0, done=0. No pass through IDLE.
- Abort: abort at row 3 -> next cycle IDLE, row_valid=0, row_idx=0, seg=0000000. A following next_btn press causes no change.
- Async reset mid-SHOW: assert rst between clock edges -> all outputs 0 immediately, without waiting for a clock edge. Release rst and reload -> normal operation.
